// File: rtl/ppu_pkg.sv
// PPU register-file constants: register indices, STATUS bits,
// default vblank lines and the palette mirror helper.
package ppu_pkg;

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_MASK    = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_OAMADDR = 3'd3;
  localparam logic [2:0] REG_OAMDATA = 3'd4;
  localparam logic [2:0] REG_SCROLL  = 3'd5;
  localparam logic [2:0] REG_ADDR    = 3'd6;
  localparam logic [2:0] REG_DATA    = 3'd7;

  localparam int ST_VBL  = 7;
  localparam int ST_SPR0 = 6;
  localparam int ST_OVF  = 5;

  localparam int VBL_SET_PY_DEF = 256;
  localparam int VBL_CLR_PY_DEF = 15;

  localparam logic [13:0] PAL_BASE = 14'h3F00;

  typedef enum logic [1:0] {
    VS_IDLE,
    VS_REQ,
    VS_CAP
  } vstate_t;

  // Sprite backdrop entries alias the background ones.
  function automatic logic [4:0] pal_mirror(
    input logic [4:0] a
  );
    if (a[4] && a[1:0] == 2'b00)
      return {1'b0, a[3:0]};
    return a;
  endfunction

endpackage

// File: rtl/ppu_regs_if.sv
// CPU-side register bus of the PPU ($2000-$2007).
interface ppu_regs_if;
  logic       ce_cpu;
  logic [2:0] cpu_a;
  logic [7:0] cpu_i;
  logic       cpu_w;
  logic       cpu_r;
  logic [7:0] cpu_o;

  modport master (
    output ce_cpu, cpu_a, cpu_i,
    output cpu_w, cpu_r,
    input  cpu_o
  );

  modport slave (
    input  ce_cpu, cpu_a, cpu_i,
    input  cpu_w, cpu_r,
    output cpu_o
  );
endinterface

// File: rtl/ppu_vram_port.sv
// $2007 VRAM port: va register, read buffer and the
// IDLE/REQ/CAP fetch FSM.
module ppu_vram_port
  import ppu_pkg::*;
(
  input  logic        clock25,
  input  logic        reset,
  input  logic        i_wr,
  input  logic        i_rd,
  input  logic [7:0]  i_d,
  input  logic        i_inc32,
  input  logic        i_load,
  input  logic [13:0] i_load_va,
  input  logic [7:0]  i_vdata,
  output logic [13:0] o_va,
  output logic [7:0]  o_buf,
  output logic [13:0] o_vaddr,
  output logic [7:0]  o_vdata,
  output logic        o_vram_we,
  output logic        o_vram_rd
);

  vstate_t     r_state;
  logic [13:0] r_va;
  logic [7:0]  r_buf;
  logic [13:0] r_vaddr;
  logic [7:0]  r_vdata;
  logic        r_we;
  logic        r_rd;
  logic        w_pal;
  logic [13:0] w_step;

  assign w_pal  = (r_va >= PAL_BASE);
  assign w_step = i_inc32 ? 14'd32 : 14'd1;

  always_ff @(posedge clock25) begin
    if (reset) begin
      r_state <= VS_IDLE;
      r_va    <= '0;
      r_buf   <= '0;
      r_vaddr <= '0;
      r_vdata <= '0;
      r_we    <= 1'b0;
      r_rd    <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (i_load)
        r_va <= i_load_va;
      else if (i_wr || i_rd)
        r_va <= r_va + w_step;
      unique case (r_state)
        VS_IDLE: begin
          if (i_rd) begin
            // palette reads refill from the nametable beneath
            r_vaddr <= w_pal ? r_va - 14'h1000 : r_va;
            r_rd    <= 1'b1;
            r_state <= VS_REQ;
          end else if (i_wr && !w_pal) begin
            r_vaddr <= r_va;
            r_vdata <= i_d;
            r_we    <= 1'b1;
          end
        end
        VS_REQ: begin
          r_rd    <= 1'b0;
          r_state <= VS_CAP;
        end
        VS_CAP: begin
          r_buf   <= i_vdata;
          r_state <= VS_IDLE;
        end
        default: r_state <= VS_IDLE;
      endcase
    end
  end

  assign o_va      = r_va;
  assign o_buf     = r_buf;
  assign o_vaddr   = r_vaddr;
  assign o_vdata   = r_vdata;
  assign o_vram_we = r_we;
  assign o_vram_rd = r_rd;

endmodule

// File: rtl/ppu_regs.sv
// PPU CPU register file ($2000-$2007), flags and NMI.
// Optional PPU_OPENBUS_EN adds the open-bus latch.
module ppu_regs
  import ppu_pkg::*;
#(
  parameter int VBL_SET_PY = VBL_SET_PY_DEF,
  parameter int VBL_CLR_PY = VBL_CLR_PY_DEF
) (
  input  logic        clock25,
  input  logic        reset,
  ppu_regs_if.slave   bus,
  input  logic [8:0]  px,
  input  logic [8:0]  py,
  input  logic        spr0_hit,
  input  logic        spr_ovf,
  output logic [7:0]  ctrl,
  output logic [7:0]  mask,
  output logic [14:0] t,
  output logic [2:0]  finex,
  output logic        t_load,
  output logic [13:0] vaddr,
  output logic [7:0]  vdata_o,
  input  logic [7:0]  vdata_i,
  output logic        vram_we,
  output logic        vram_rd,
  output logic [4:0]  pal_a,
  output logic [5:0]  pal_d,
  output logic        pal_we,
  input  logic [5:0]  pal_i,
  output logic [7:0]  oam_a,
  output logic [7:0]  oam_d,
  output logic        oam_we,
  input  logic [7:0]  oam_i,
  output logic        nmi
);

  logic [7:0]  r_ctrl;
  logic [7:0]  r_mask;
  logic [14:0] r_t;
  logic [2:0]  r_finex;
  logic        r_w;
  logic        r_t_load;
  logic        r_vblank;
  logic        r_spr0;
  logic        r_ovf;
  logic [7:0]  r_oam_a;
  logic [7:0]  r_oam_d;
  logic        r_oam_we;
  logic [4:0]  r_pal_wa;
  logic [5:0]  r_pal_d;
  logic        r_pal_we;
  logic [7:0]  r_cpu_o;

  logic        w_wr;
  logic        w_rd;
  logic [7:0]  w_sel;
  logic        w_vbl_set;
  logic        w_vbl_clr;
  logic [13:0] w_va;
  logic [7:0]  w_buf;
  logic [7:0]  w_ob;
  logic [7:0]  w_rdata;

  assign w_wr  = bus.ce_cpu & bus.cpu_w;
  assign w_rd  = bus.ce_cpu & bus.cpu_r & ~bus.cpu_w;
  assign w_sel = 8'd1 << bus.cpu_a;

  assign w_vbl_set = (py == 9'(VBL_SET_PY)) && (px == 9'd1);
  assign w_vbl_clr = (py == 9'(VBL_CLR_PY)) && (px == 9'd1);

`ifdef PPU_OPENBUS_EN
  logic [7:0] r_ob;
  always_ff @(posedge clock25) begin
    if (reset)
      r_ob <= '0;
    else if (w_wr)
      r_ob <= bus.cpu_i;
    else if (w_rd)
      r_ob <= w_rdata;
  end
  assign w_ob = r_ob;
`else
  assign w_ob = 8'h00;
`endif

  always_comb begin
    w_rdata = w_ob;
    unique case (1'b1)
      w_sel[REG_STATUS]:
        w_rdata = {r_vblank, r_spr0, r_ovf, w_ob[4:0]};
      w_sel[REG_OAMDATA]:
        w_rdata = oam_i;
      w_sel[REG_DATA]:
        w_rdata = (w_va >= PAL_BASE) ? {2'b00, pal_i} : w_buf;
      default: ;
    endcase
  end

  always_ff @(posedge clock25) begin
    if (reset) begin
      r_ctrl   <= '0;
      r_mask   <= '0;
      r_t      <= '0;
      r_finex  <= '0;
      r_w      <= 1'b0;
      r_t_load <= 1'b0;
      r_vblank <= 1'b0;
      r_spr0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_oam_a  <= '0;
      r_oam_d  <= '0;
      r_oam_we <= 1'b0;
      r_pal_wa <= '0;
      r_pal_d  <= '0;
      r_pal_we <= 1'b0;
      r_cpu_o  <= '0;
    end else begin
      r_t_load <= 1'b0;
      r_oam_we <= 1'b0;
      r_pal_we <= 1'b0;
      if (r_oam_we)
        r_oam_a <= r_oam_a + 8'd1;
      if (w_vbl_clr) begin
        r_vblank <= 1'b0;
        r_spr0   <= 1'b0;
        r_ovf    <= 1'b0;
      end else begin
        if (spr0_hit)  r_spr0   <= 1'b1;
        if (spr_ovf)   r_ovf    <= 1'b1;
        if (w_vbl_set) r_vblank <= 1'b1;
      end
      if (w_rd)
        r_cpu_o <= w_rdata;
      // a status read on the set cycle suppresses the frame's vblank
      if (w_rd && w_sel[REG_STATUS]) begin
        r_vblank <= 1'b0;
        r_w      <= 1'b0;
      end
      if (w_wr) begin
        unique case (1'b1)
          w_sel[REG_CTRL]: begin
            r_ctrl      <= bus.cpu_i;
            r_t[11:10]  <= bus.cpu_i[1:0];
          end
          w_sel[REG_MASK]:
            r_mask <= bus.cpu_i;
          w_sel[REG_OAMADDR]:
            r_oam_a <= bus.cpu_i;
          w_sel[REG_OAMDATA]: begin
            r_oam_d  <= bus.cpu_i;
            r_oam_we <= 1'b1;
          end
          w_sel[REG_SCROLL]: begin
            if (!r_w) begin
              r_finex  <= bus.cpu_i[2:0];
              r_t[4:0] <= bus.cpu_i[7:3];
            end else begin
              r_t[14:12] <= bus.cpu_i[2:0];
              r_t[9:5]   <= bus.cpu_i[7:3];
            end
            r_w <= ~r_w;
          end
          w_sel[REG_ADDR]: begin
            if (!r_w) begin
              r_t[13:8] <= bus.cpu_i[5:0];
              r_t[14]   <= 1'b0;
            end else begin
              r_t[7:0] <= bus.cpu_i;
              r_t_load <= 1'b1;
            end
            r_w <= ~r_w;
          end
          w_sel[REG_DATA]: begin
            if (w_va >= PAL_BASE) begin
              r_pal_wa <= pal_mirror(w_va[4:0]);
              r_pal_d  <= bus.cpu_i[5:0];
              r_pal_we <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  ppu_vram_port u_vram (
    .clock25   (clock25),
    .reset     (reset),
    .i_wr      (w_wr & w_sel[REG_DATA]),
    .i_rd      (w_rd & w_sel[REG_DATA]),
    .i_d       (bus.cpu_i),
    .i_inc32   (r_ctrl[2]),
    .i_load    (w_wr & w_sel[REG_ADDR] & r_w),
    .i_load_va ({r_t[13:8], bus.cpu_i}),
    .i_vdata   (vdata_i),
    .o_va      (w_va),
    .o_buf     (w_buf),
    .o_vaddr   (vaddr),
    .o_vdata   (vdata_o),
    .o_vram_we (vram_we),
    .o_vram_rd (vram_rd)
  );

  // write address is held for the strobe cycle; reads track va
  assign pal_a = r_pal_we ? r_pal_wa
                          : pal_mirror(w_va[4:0]);

  assign bus.cpu_o = r_cpu_o;
  assign ctrl      = r_ctrl;
  assign mask      = r_mask;
  assign t         = r_t;
  assign finex     = r_finex;
  assign t_load    = r_t_load;
  assign pal_d     = r_pal_d;
  assign pal_we    = r_pal_we;
  assign oam_a     = r_oam_a;
  assign oam_d     = r_oam_d;
  assign oam_we    = r_oam_we;
  assign nmi       = r_vblank & r_ctrl[7];

endmodule

// File: doc/ppu_regs.md
# ppu_regs

CPU-facing register file of the PPU, mapped at $2000–$2007. It sits between the CPU data bus and the rendering core. It holds CTRL, MASK and STATUS, the scroll/address latch pair (`t`, fine X, write toggle) and the OAM address. It executes $2007 VRAM/palette accesses through its own memory port, and drives NMI from the vblank flag.

## Interface
Parameters:
- `VBL_SET_PY`, default 256: py on which vblank is set (at px=1).
- `VBL_CLR_PY`, default 15: pre-render py; vblank, sprite-0 and overflow flags are cleared here (at px=1).

Ports:
- `clock25` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `ce_cpu` in 1: CPU cycle enable; bus strobes are honoured only when high.
- `cpu_a` in 3: register select ($2000+n).
- `cpu_i` in 8: write data.
- `cpu_w` in 1: write strobe.
- `cpu_r` in 1: read strobe.
- `cpu_o` out 8: registered read data.
- `px` in 9, `py` in 9: PPU beam counters.
- `spr0_hit` in 1, `spr_ovf` in 1: set pulses from the sprite unit.
- `ctrl` out 8, `mask` out 8: register values.
- `t` out 15: loopy temporary address.
- `finex` out 3: fine X scroll.
- `t_load` out 1: one-cycle pulse on the second $2006 write (core copies t→v).
- `vaddr` out 14: VRAM address for $2007.
- `vdata_o` out 8: VRAM write data.
- `vdata_i` in 8: VRAM read data, 1-cycle latency.
- `vram_we` out 1: VRAM write.
- `vram_rd` out 1: VRAM read request.
- `pal_a` out 5: palette address.
- `pal_d` out 6: palette write data.
- `pal_we` out 1: palette write.
- `pal_i` in 6: palette read data, combinational.
- `oam_a` out 8: OAM address.
- `oam_d` out 8: OAM write data.
- `oam_we` out 1: OAM write.
- `oam_i` in 8: OAM read data.
- `nmi` out 1: level, equal to vblank & ctrl[7].

## Operation
- An access is `ce_cpu & (cpu_w | cpu_r)`. If both strobes are high, the write wins.
- $2000 write: ctrl←d; t[11:10]←d[1:0].
- $2001 write: mask←d.
- $2002 read: returns {vblank, spr0, ovf, 5'b0}, then clears vblank and w.
- $2003 write: oam_a←d.
- $2004 write: oam_d←d, oam_we pulse, then oam_a+1 (wraps 255→0).
- $2004 read: returns oam_i; oam_a does not change.
- $2005 write with w=0: finex←d[2:0], t[4:0]←d[7:3].
- $2005 write with w=1: t[14:12]←d[2:0], t[9:5]←d[7:3].
- Each $2005/$2006 write toggles w.
- $2006 write with w=0: t[13:8]←d[5:0], t[14]←0.
- $2006 write with w=1: t[7:0]←d, va←{t[13:8], d}, t_load pulse.
- $2007 increments va by 1 or 32 (ctrl[2]); va is 14 bits and wraps $3FFF→$0000.
- $2007 write:
  - va<$3F00: vaddr=va, vdata_o=d, vram_we pulse.
  - Otherwise: pal_a=va[4:0] with $10/$14/$18/$1C mirrored to $00/$04/$08/$0C, pal_d=d[5:0], pal_we pulse.
- $2007 read, va<$3F00: returns the read buffer; VRAM FSM refills the buffer from va.
- $2007 read, va≥$3F00: returns {2'b00, pal_i}; buffer refilled from va−$1000 (nametable beneath).
- VRAM FSM states:
  - IDLE → REQ on a $2007 read. REQ drives vaddr and vram_rd for one cycle.
  - REQ → CAP. CAP latches vdata_i into the buffer.
  - CAP → IDLE.
  - A $2007 access arriving outside IDLE is impossible: ce_cpu spacing is ≥3.
- Flags:
  - At (VBL_SET_PY, px=1): vblank←1.
  - At (VBL_CLR_PY, px=1): vblank, spr0 and ovf←0.
  - spr0_hit/spr_ovf set their sticky bits.
- Simultaneous $2002 read and vblank set: the read returns 0, and vblank stays 0 for that frame.
- nmi follows ctrl[7] immediately, so writing ctrl[7]=1 inside vblank raises nmi the next cycle.

## Timing
- cpu_o is updated the cycle after the access and held until the next read.
- Read side effects (flag clear, va increment) take effect the same edge as the cpu_o update.
- The refilled $2007 buffer is valid 3 cycles after the read strobe (REQ, CAP, settle); that is before the next ce_cpu.
- Strobes vram_we, pal_we, oam_we and t_load are high exactly one cycle, the cycle after the access.
- Reset: all registers, outputs and strobes are 0; FSM is IDLE.

## Configuration
- `PPU_OPENBUS_EN` defined:
  - An internal open-bus latch holds the last written or read byte.
  - Reads of write-only registers ($2000, $2001, $2003, $2005, $2006) return the latch.
  - $2002 bits[4:0] come from the latch.
- `PPU_OPENBUS_EN` undefined: those reads and bits return 0, and no latch is built.

## Structure
- `ppu_pkg` holds the register index constants and STATUS bit positions.
- `ppu_pkg` also holds the default VBL_SET_PY/VBL_CLR_PY values and the palette mirror function.
- One sub-module, `ppu_vram_port`: the IDLE/REQ/CAP FSM, the read buffer and the va increment.

## Test plan
- **Scroll writes:** write $2005=$7D, then $2005=$5E → finex=5, t=$616F, w returns to 0.
- **Address then write:**
  - Write $2006=$21, $2006=$08 → t_load pulse, t=$2108.
  - Write $2007=$AB with ctrl[2]=0 → vram_we at vaddr $2108, va=$2109.
  - With ctrl[2]=1 → va=$2128.
- **Buffered read:**
  - Preload VRAM $2400=$11, $2401=$22.
  - Set va=$2400; read $2007 three times → returns stale, then $11, then $22.
- **Palette mirror:** va=$3F10, write $2007=$2A → pal_we, pal_a=$00, pal_d=$2A; a read returns pal_i.
- **Vblank and NMI:**
  - At py=256, px=1 → vblank=1; with ctrl[7]=1, nmi=1.
  - Read $2002 → returns $80, then nmi=0.
  - A read landing exactly on the set cycle returns $00, and no NMI occurs that frame.
- **Reset mid-access:** assert reset during REQ → FSM IDLE, all strobes low, cpu_o=0, w=0.
